// File: rtl/ahb_mailbox_mc.sv
// Multi-channel AHB-Lite mailbox: per-channel message FIFO with count, threshold interrupt and flush.
// Define AHB_MAILBOX_ERR_RESP_EN to answer illegal accesses with a two-cycle ERROR response.
module ahb_mailbox_mc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic                  hwrite,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic [NUM_CH-1:0]     irq,
  output logic                  mailbox_intr
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_CTRL, REG_IRQ} reg_e;

  logic          dp_valid, dp_legal, dp_write;
  logic [3:0]    dp_ch;
  reg_e          dp_reg;
  logic          a_valid, a_legal, acc;

  logic [PW-1:0] wr_ptr [NUM_CH];
  logic [PW-1:0] rd_ptr [NUM_CH];
  logic [PW-1:0] wr_n   [NUM_CH];
  logic [PW-1:0] rd_n   [NUM_CH];
  logic [PW-1:0] cnt    [NUM_CH];
  logic [10:0]   thr    [NUM_CH];
  logic [10:0]   thr_n  [NUM_CH];
  logic [NUM_CH-1:0] irq_en, en_n, pend, pend_n, ovf, ovf_n, udf, udf_n;
  logic [NUM_CH-1:0] empty, full, push;
  logic [DATA_WIDTH-1:0] mem [NUM_CH][DEPTH];
  logic          unused_bits;

  assign unused_bits = ^{haddr[ADDR_WIDTH-1:8], htrans[0]};
  assign a_valid = hsel & hready & htrans[1];
  assign a_legal = ({1'b0, haddr[7:4]} < 5'(NUM_CH)) && (hsize == 3'b010) && (haddr[1:0] == 2'b00);
  assign acc     = dp_valid & dp_legal & hready;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dp_valid <= 1'b0;
      dp_legal <= 1'b0;
      dp_write <= 1'b0;
      dp_ch    <= '0;
      dp_reg   <= REG_DATA;
    end else if (hready) begin
      dp_valid <= a_valid;
      dp_legal <= a_legal;
      dp_write <= hwrite;
      dp_ch    <= haddr[7:4];
      dp_reg   <= reg_e'(haddr[3:2]);
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      cnt[c]   = wr_ptr[c] - rd_ptr[c];
      empty[c] = (wr_ptr[c] == rd_ptr[c]);
      full[c]  = ((wr_ptr[c] ^ rd_ptr[c]) == {1'b1, {AW{1'b0}}});
    end
  end

  // Single access per cycle, so at most one channel/register changes; set-over-clear holds trivially.
  always_comb begin
    wr_n   = wr_ptr;
    rd_n   = rd_ptr;
    thr_n  = thr;
    en_n   = irq_en;
    pend_n = pend;
    ovf_n  = ovf;
    udf_n  = udf;
    push   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (acc && dp_ch == 4'(c)) begin
        case (dp_reg)
          REG_DATA: begin
            if (dp_write) begin
              if (full[c]) begin
                ovf_n[c] = 1'b1;
              end else begin
                push[c] = 1'b1;
                wr_n[c] = wr_ptr[c] + 1'b1;
                if (thr[c] != '0 && 11'(cnt[c]) + 11'd1 == thr[c]) pend_n[c] = 1'b1;
              end
            end else if (empty[c]) begin
              udf_n[c] = 1'b1;
            end else begin
              rd_n[c] = rd_ptr[c] + 1'b1;
            end
          end
          REG_STATUS: if (dp_write) begin
            ovf_n[c] = ovf[c] & ~hwdata[18];
            udf_n[c] = udf[c] & ~hwdata[19];
          end
          REG_CTRL: if (dp_write) begin
            thr_n[c] = hwdata[10:0];
            en_n[c]  = hwdata[16];
            if (hwdata[17]) rd_n[c] = wr_ptr[c];
          end
          default: if (dp_write) pend_n[c] = pend[c] & ~hwdata[0];
        endcase
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        thr[c]    <= '0;
      end
      irq_en       <= '0;
      pend         <= '0;
      ovf          <= '0;
      udf          <= '0;
      irq          <= '0;
      mailbox_intr <= 1'b0;
    end else begin
      wr_ptr       <= wr_n;
      rd_ptr       <= rd_n;
      thr          <= thr_n;
      irq_en       <= en_n;
      pend         <= pend_n;
      ovf          <= ovf_n;
      udf          <= udf_n;
      irq          <= pend_n & en_n;
      mailbox_intr <= |(pend_n & en_n);
    end
  end

  always_ff @(posedge hclk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wr_ptr[c][AW-1:0]] <= hwdata;
    end
  end

  always_comb begin
    hrdata = '0;
    if (dp_valid && dp_legal && !dp_write) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (dp_ch == 4'(c)) begin
          case (dp_reg)
            REG_DATA:   hrdata = empty[c] ? '0 : mem[c][rd_ptr[c][AW-1:0]];
            REG_STATUS: hrdata = DATA_WIDTH'({12'b0, udf[c], ovf[c], full[c], empty[c], 5'b0, 11'(cnt[c])});
            REG_CTRL:   hrdata = DATA_WIDTH'({15'b0, irq_en[c], 5'b0, thr[c]});
            default:    hrdata = DATA_WIDTH'(pend[c]);
          endcase
        end
      end
    end
  end

`ifdef AHB_MAILBOX_ERR_RESP_EN
  logic rdy_q, err_q;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      rdy_q <= 1'b1;
      err_q <= 1'b0;
    end else if (!rdy_q) begin
      rdy_q <= 1'b1;
      err_q <= 1'b1;
    end else if (a_valid && !a_legal) begin
      rdy_q <= 1'b0;
      err_q <= 1'b1;
    end else begin
      err_q <= 1'b0;
    end
  end

  assign hreadyout = rdy_q;
  assign hresp     = {1'b0, err_q};
`else
  assign hreadyout = 1'b1;
  assign hresp     = '0;
`endif
endmodule

// File: tb/tb_ahb_mailbox_mc.sv
// Bench for ahb_mailbox_mc: directed scenarios plus random traffic against a queue-based mailbox model.
module tb_ahb_mailbox_mc;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;

  logic        hclk = 1'b0;
  logic        hreset, hsel, hwrite, hready;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize;
  logic        hreadyout, mailbox_intr;
  logic [NUM_CH-1:0] irq;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] mq [NUM_CH][$];
  logic [10:0] m_thr  [NUM_CH];
  logic [NUM_CH-1:0] m_en, m_pend, m_ovf, m_udf;

  ahb_mailbox_mc #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hready(hready), .hwdata(hwdata), .hreadyout(hreadyout), .hresp(hresp),
    .hrdata(hrdata), .irq(irq), .mailbox_intr(mailbox_intr)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] A(input int c, input int r);
    return 32'((c << 4) | (r << 2));
  endfunction

  // ---- reference model ----
  task automatic m_push(input int c, input logic [31:0] w);
    if (mq[c].size() == DEPTH) m_ovf[c] = 1'b1;
    else begin
      mq[c].push_back(w);
      if (m_thr[c] != 0 && mq[c].size() == int'(m_thr[c])) m_pend[c] = 1'b1;
    end
  endtask

  task automatic m_pop(input int c, output logic [31:0] w);
    if (mq[c].size() == 0) begin w = '0; m_udf[c] = 1'b1; end
    else w = mq[c].pop_front();
  endtask

  function automatic logic [31:0] m_status(input int c);
    int n = mq[c].size();
    return {12'b0, m_udf[c], m_ovf[c], n == DEPTH, n == 0, 5'b0, 11'(n)};
  endfunction

  function automatic logic [NUM_CH-1:0] m_irq();
    return m_pend & m_en;
  endfunction

  // ---- bus access, entered and left 1 time unit after a rising edge ----
  task automatic bus(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                     input logic [31:0] wdata, output logic [31:0] rdata);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = sz;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wdata;
    rdata = hrdata;
    @(posedge hclk); #1;
  endtask

  task automatic chk_irq();
    chk("irq", 32'(irq), 32'(m_irq()));
    chk("mailbox_intr", 32'(mailbox_intr), 32'(|m_irq()));
  endtask

  task automatic do_push(input int c, input logic [31:0] w);
    logic [31:0] d;
    bus(A(c, 0), 1'b1, 3'b010, w, d);
    m_push(c, w);
    chk_irq();
  endtask

  task automatic do_pop(input int c);
    logic [31:0] d, e;
    bus(A(c, 0), 1'b0, 3'b010, '0, d);
    m_pop(c, e);
    chk($sformatf("pop ch%0d", c), d, e);
  endtask

  task automatic do_status(input int c);
    logic [31:0] d;
    bus(A(c, 1), 1'b0, 3'b010, '0, d);
    chk($sformatf("status ch%0d", c), d, m_status(c));
  endtask

  task automatic do_wreg(input int c, input int r, input logic [31:0] w);
    logic [31:0] d;
    bus(A(c, r), 1'b1, 3'b010, w, d);
    if (r == 1) begin
      if (w[18]) m_ovf[c] = 1'b0;
      if (w[19]) m_udf[c] = 1'b0;
    end else if (r == 2) begin
      m_thr[c] = w[10:0];
      m_en[c]  = w[16];
      if (w[17]) mq[c].delete();
    end else if (r == 3 && w[0]) m_pend[c] = 1'b0;
    chk_irq();
  endtask

  task automatic do_rreg(input int c, input int r);
    logic [31:0] d;
    bus(A(c, r), 1'b0, 3'b010, '0, d);
    if (r == 2) chk("ctrl", d, {15'b0, m_en[c], 5'b0, m_thr[c]});
    else        chk("irqreg", d, 32'(m_pend[c]));
  endtask

  task automatic illegal(input logic [31:0] addr, input logic wr, input logic [2:0] sz);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = sz;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hDEAD_BEEF;
`ifdef AHB_MAILBOX_ERR_RESP_EN
    chk("err c1 hreadyout", 32'(hreadyout), 32'd0);
    chk("err c1 hresp", 32'(hresp), 32'd1);
    hready = 1'b0;
    @(posedge hclk); #1;
    hready = 1'b1;
    chk("err c2 hreadyout", 32'(hreadyout), 32'd1);
    chk("err c2 hresp", 32'(hresp), 32'd1);
`else
    chk("illegal hrdata", hrdata, 32'd0);
    chk("illegal hresp", 32'(hresp), 32'd0);
    chk("illegal hreadyout", 32'(hreadyout), 32'd1);
`endif
    @(posedge hclk); #1;
  endtask

  initial begin
    logic [31:0] d, e, w;
    hreset = 1'b1; hsel = 1'b0; haddr = '0; htrans = '0; hsize = 3'b010;
    hwrite = 1'b0; hready = 1'b1; hwdata = '0;
    for (int c = 0; c < NUM_CH; c++) m_thr[c] = '0;
    m_en = '0; m_pend = '0; m_ovf = '0; m_udf = '0;
    repeat (2) @(posedge hclk);
    #1 hreset = 1'b0;

    // reset state
    chk("reset hrdata", hrdata, 32'd0);
    chk("reset irq", 32'(irq), 32'd0);
    chk("reset mailbox_intr", 32'(mailbox_intr), 32'd0);
    chk("reset hreadyout", 32'(hreadyout), 32'd1);
    chk("reset hresp", 32'(hresp), 32'd0);
    for (int c = 0; c < NUM_CH; c++) begin
      bus(A(c, 1), 1'b0, 3'b010, '0, d);
      chk("reset status", d, 32'h0001_0000);
    end

    // threshold interrupt on ch1
    do_wreg(1, 2, 32'h0001_0003);
    do_rreg(1, 2);
    do_push(1, 32'hA);
    do_push(1, 32'hB);
    chk("irq before thr", 32'(irq), 32'd0);
    do_push(1, 32'hC);
    chk("irq1 after thr", 32'(irq), 32'b0010);
    chk("mailbox_intr after thr", 32'(mailbox_intr), 32'd1);
    do_rreg(1, 3);
    for (int i = 0; i < 3; i++) begin
      bus(A(1, 0), 1'b0, 3'b010, '0, d);
      m_pop(1, e);
      chk("ch1 pop literal", d, 32'hA + 32'(i));
    end
    do_wreg(1, 3, 32'h1);
    chk("irq1 cleared", 32'(irq), 32'd0);

    // overflow / underflow on ch0
    for (int i = 1; i <= DEPTH + 1; i++) do_push(0, 32'(i));
    bus(A(0, 1), 1'b0, 3'b010, '0, d);
    chk("ch0 full status", d, 32'h0006_0010);
    for (int i = 1; i <= DEPTH; i++) begin
      bus(A(0, 0), 1'b0, 3'b010, '0, d);
      m_pop(0, e);
      chk("ch0 pop order", d, 32'(i));
    end
    do_pop(0);
    bus(A(0, 1), 1'b0, 3'b010, '0, d);
    chk("ch0 udf status", d, 32'h000D_0000);
    do_wreg(0, 1, 32'h000C_0000);
    bus(A(0, 1), 1'b0, 3'b010, '0, d);
    chk("ch0 w1c status", d, 32'h0001_0000);

    // flush and pointer wrap on ch2
    for (int i = 0; i < 5; i++) do_push(2, 32'h200 + 32'(i));
    do_status(2);
    do_wreg(2, 2, 32'h0002_0000);
    bus(A(2, 1), 1'b0, 3'b010, '0, d);
    chk("ch2 after flush", d, 32'h0001_0000);
    do_rreg(2, 2);
    do_push(2, 32'h55);
    bus(A(2, 0), 1'b0, 3'b010, '0, d);
    m_pop(2, e);
    chk("ch2 pop 0x55", d, 32'h55);
    for (int i = 0; i < 40; i++) begin
      do_push(2, $urandom);
      do_pop(2);
    end
    do_status(2);

    // back-to-back write then read on ch3
    w = 32'hCAFE_0003;
    hsel = 1'b1; htrans = 2'b10; haddr = A(3, 0); hwrite = 1'b1; hsize = 3'b010;
    @(posedge hclk); #1;
    hwdata = w; hwrite = 1'b0;
    @(posedge hclk); #1;
    d = hrdata;
    hsel = 1'b0; htrans = 2'b00;
    @(posedge hclk); #1;
    m_push(3, w);
    m_pop(3, e);
    chk("b2b read", d, 32'hCAFE_0003);
    do_status(3);

    // illegal accesses change nothing
    do_push(0, 32'h77);
    illegal(A(NUM_CH, 0), 1'b0, 3'b010);
    illegal(A(NUM_CH, 0), 1'b1, 3'b010);
    illegal(A(0, 0), 1'b0, 3'b000);
    illegal(A(0, 0), 1'b1, 3'b000);
    illegal(A(0, 0) | 32'h1, 1'b0, 3'b010);
    do_status(0);
    do_pop(0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      int c, op;
      c  = int'($urandom_range(0, NUM_CH - 1));
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1, 2, 3: do_push(c, $urandom);
        4, 5:       do_pop(c);
        6:          do_status(c);
        7:          do_wreg(c, 2, {14'b0, ($urandom_range(0, 11) == 0), 1'($urandom),
                                   5'b0, 11'($urandom_range(0, DEPTH + 2))});
        8:          do_wreg(c, ($urandom_range(0, 1) == 0) ? 1 : 3,
                            {12'b0, 2'($urandom), 17'b0, 1'($urandom)});
        default:    do_rreg(c, ($urandom_range(0, 1) == 0) ? 2 : 3);
      endcase
    end
    for (int c = 0; c < NUM_CH; c++) do_status(c);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
